calc_diff_accum: RTL

//   Downstream consumer of the CALC difference stage: collects a window of signed

---
 rtl/calc_diff_accum.sv | 102 ++++++++++
 1 files changed

// File: rtl/calc_diff_accum.sv
// rtl/calc_diff_accum.sv - windowed signed accumulator of CALC difference samples (option: CALC_ACC_SAT_EN)
module calc_diff_accum #(
    parameter int WD    = 8,
    parameter int ACC_W = 16,
    parameter int LEN_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [LEN_W-1:0] win_len,
    input  logic             in_valid,
    input  logic [WD-1:0]    in_data,
    output logic             in_ready,
    output logic             busy,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_sum,
    output logic [LEN_W-1:0] out_count,
    output logic             overflow
);

    typedef enum logic [1:0] {IDLE, ACCUM, HOLD} state_t;

    localparam logic [ACC_W-1:0] SUM_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic [ACC_W-1:0] SUM_MIN = {1'b1, {(ACC_W-1){1'b0}}};

    state_t           state, state_nx;
    logic [LEN_W-1:0] len_q, len_nx;
    logic [LEN_W-1:0] count_nx, count_inc;
    logic [ACC_W-1:0] sum_nx, sample_ext, add_raw, add_res;
    logic             ovf_nx, add_ovf, accept;

    assign sample_ext = {{(ACC_W-WD){in_data[WD-1]}}, in_data};
    assign add_raw    = out_sum + sample_ext;
    assign add_ovf    = (out_sum[ACC_W-1] == sample_ext[ACC_W-1]) &&
                        (add_raw[ACC_W-1] != out_sum[ACC_W-1]);
    assign count_inc  = out_count + LEN_W'(1);
    assign accept     = in_valid && in_ready;

`ifdef CALC_ACC_SAT_EN
    // Clamp toward the sign of the running sum; later samples add from the rail.
    assign add_res = add_ovf ? (out_sum[ACC_W-1] ? SUM_MIN : SUM_MAX) : add_raw;
`else
    assign add_res = add_raw;
`endif

    always_comb begin
        state_nx = state;
        len_nx   = len_q;
        count_nx = out_count;
        sum_nx   = out_sum;
        ovf_nx   = overflow;
        case (state)
            IDLE: begin
                if (start) begin
                    len_nx   = win_len;
                    count_nx = '0;
                    sum_nx   = '0;
                    ovf_nx   = 1'b0;
                    state_nx = (win_len == '0) ? HOLD : ACCUM;
                end
            end
            ACCUM: begin
                if (accept) begin
                    sum_nx   = add_res;
                    count_nx = count_inc;
                    ovf_nx   = overflow | add_ovf;
                    if (count_inc == len_q)
                        state_nx = HOLD;
                end
            end
            HOLD: begin
                if (out_ready)
                    state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            len_q     <= '0;
            out_count <= '0;
            out_sum   <= '0;
            overflow  <= 1'b0;
            in_ready  <= 1'b0;
            busy      <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            state     <= state_nx;
            len_q     <= len_nx;
            out_count <= count_nx;
            out_sum   <= sum_nx;
            overflow  <= ovf_nx;
            in_ready  <= (state_nx == ACCUM);
            busy      <= (state_nx != IDLE);
            out_valid <= (state_nx == HOLD);
        end
    end

endmodule
